// File: rtl/opendap_mem_ap_apb.sv
// MEM-AP behind the SW-DP: decodes the MEM-AP register map and bridges DRW/BDn to an APB3 master.
// Build option OPENDAP_MEM_AP_BANKED_DATA_EN enables BD0-BD3 as APB windows; otherwise they are RAZ/WI.
module opendap_mem_ap_apb #(
    parameter logic [7:0]  APSEL = 8'd0,
    parameter logic [31:0] IDR   = 32'h0477_0002,
    parameter logic [31:0] BASE  = 32'h0000_0003
) (
    input  logic        swclk,
    input  logic        rst,
    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_wen,
    input  logic        ap_ren,
    input  logic        ap_abort,
    output logic [31:0] ap_rdata,
    output logic        ap_rdy,
    output logic        ap_err,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state;
    logic [1:0]  addr_inc;
    logic [31:2] tar;
    logic        orphan, cur_drw;
    logic        pend, pend_write, pend_drw;
    logic [31:0] pend_addr, pend_wdata;

    logic        acc, hit, is_drw, is_bd, xfer, busy;
    logic        launch_in, launch_pend, launch;
    logic [31:0] xfer_addr, reg_rd;
    logic [31:0] l_addr, l_wdata;
    logic        l_write, l_drw;

    always_comb begin
        acc    = (ap_wen | ap_ren) & ap_rdy;
        hit    = acc && (ap_sel == APSEL);
        is_drw = (ap_addr == 6'h03);
        busy   = (state != IDLE);
`ifdef OPENDAP_MEM_AP_BANKED_DATA_EN
        is_bd     = (ap_addr[5:2] == 4'b0001);
        xfer_addr = is_bd ? {tar[31:4], ap_addr[1:0], 2'b00} : {tar, 2'b00};
`else
        is_bd     = 1'b0;
        xfer_addr = {tar, 2'b00};
`endif
        xfer = hit && (is_drw || is_bd);

        case (ap_addr)
            6'h00:   reg_rd = {24'h0, busy, 1'b1, addr_inc, 1'b0, 3'b010};
            6'h01:   reg_rd = {tar, 2'b00};
            6'h3E:   reg_rd = BASE;
            6'h3F:   reg_rd = IDR;
            default: reg_rd = 32'h0;
        endcase

        // A queued access behind an orphan goes out as soon as the orphan's pready lands.
        launch_in   = xfer && !busy && !pend;
        launch_pend = pend && !ap_abort &&
                      (!busy || (state == ACCESS && pready && orphan));
        launch      = launch_in || launch_pend;
        l_addr      = launch_pend ? pend_addr  : xfer_addr;
        l_write     = launch_pend ? pend_write : ap_wen;
        l_wdata     = launch_pend ? pend_wdata : (ap_wen ? ap_wdata : pwdata);
        l_drw       = launch_pend ? pend_drw   : is_drw;
    end

    always_ff @(posedge swclk) begin
        if (rst) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 32'h0;
            pwdata     <= 32'h0;
            ap_rdata   <= 32'h0;
            ap_rdy     <= 1'b1;
            ap_err     <= 1'b0;
            addr_inc   <= 2'b00;
            tar        <= '0;
            orphan     <= 1'b0;
            cur_drw    <= 1'b0;
            pend       <= 1'b0;
            pend_write <= 1'b0;
            pend_drw   <= 1'b0;
            pend_addr  <= 32'h0;
            pend_wdata <= 32'h0;
        end else begin
            ap_err <= 1'b0;

            if (acc && !hit && ap_ren)
                ap_rdata <= 32'h0;
            if (hit && !xfer) begin
                if (ap_ren)
                    ap_rdata <= reg_rd;
                if (ap_wen && ap_addr == 6'h00)
                    addr_inc <= ap_wdata[5:4];
                if (ap_wen && ap_addr == 6'h01)
                    tar <= ap_wdata[31:2];
            end

            if (xfer && busy) begin
                pend       <= 1'b1;
                pend_addr  <= xfer_addr;
                pend_write <= ap_wen;
                pend_wdata <= ap_wen ? ap_wdata : pend_wdata;
                pend_drw   <= is_drw;
                ap_rdy     <= 1'b0;
            end

            if (launch) begin
                state   <= SETUP;
                psel    <= 1'b1;
                penable <= 1'b0;
                paddr   <= l_addr;
                pwrite  <= l_write;
                pwdata  <= l_wdata;
                cur_drw <= l_drw;
                orphan  <= 1'b0;
                pend    <= 1'b0;
                ap_rdy  <= 1'b0;
            end else begin
                case (state)
                    SETUP: begin
                        penable <= 1'b1;
                        state   <= ACCESS;
                    end
                    ACCESS: if (pready) begin
                        state   <= IDLE;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        orphan  <= 1'b0;
                        if (!orphan && !ap_abort) begin
                            ap_rdy <= 1'b1;
                            ap_err <= pslverr;
                            if (!pwrite)
                                ap_rdata <= prdata;
                            if (cur_drw && addr_inc == 2'b01 && !pslverr)
                                tar[9:2] <= tar[9:2] + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // Abort releases the DP immediately; the bus side finishes on its own.
            if (ap_abort && busy && !orphan) begin
                ap_rdy <= 1'b1;
                ap_err <= 1'b0;
                if (!(state == ACCESS && pready))
                    orphan <= 1'b1;
            end
            if (ap_abort && pend) begin
                pend   <= 1'b0;
                ap_rdy <= 1'b1;
                ap_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_opendap_mem_ap_apb.sv
// Scoreboard bench for opendap_mem_ap_apb: driver queues expected AP responses and APB requests,
// monitors on the AP and APB sides pop and compare.
module tb_opendap_mem_ap_apb;
    logic        swclk = 1'b0;
    logic        rst;
    logic [7:0]  ap_sel;
    logic [5:0]  ap_addr;
    logic [31:0] ap_wdata;
    logic        ap_wen, ap_ren, ap_abort;
    logic [31:0] ap_rdata;
    logic        ap_rdy, ap_err;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;

    opendap_mem_ap_apb dut (
        .swclk(swclk), .rst(rst), .ap_sel(ap_sel), .ap_addr(ap_addr), .ap_wdata(ap_wdata),
        .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_abort(ap_abort), .ap_rdata(ap_rdata),
        .ap_rdy(ap_rdy), .ap_err(ap_err), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 swclk = ~swclk;

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        err;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // AP-side monitor: a strobe opens a response window, the first rdy-high cycle closes it.
    logic mon_pend = 1'b0;
    logic err_next = 1'b0;
    int   lat = 0;
    initial forever begin
        @(negedge swclk);
        if (rst) begin
            mon_pend = 1'b0;
            err_next = 1'b0;
        end else begin
            if (err_next) begin
                chk("err_one_cycle", {31'h0, ap_err}, 32'h0);
                err_next = 1'b0;
            end
            if (mon_pend) begin
                lat++;
                if (ap_rdy) begin
                    rsp_t r;
                    mon_pend = 1'b0;
                    err_next = 1'b1;
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'h1, 32'h0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_err", {31'h0, ap_err}, {31'h0, r.err});
                        if (r.chk) chk("rsp_rdata", ap_rdata, r.rdata);
                        if (r.lat != 0) chk("rsp_latency", lat, r.lat);
                    end
                end else if (lat > 80) begin
                    chk("rsp_timeout", lat, 0);
                    mon_pend = 1'b0;
                end
            end
            if ((ap_wen || ap_ren) && ap_rdy && !mon_pend) begin
                mon_pend = 1'b1;
                lat = 0;
            end
        end
    end

    // APB-side monitor and slave model.
    apb_t cur;
    int   acnt = 0;
    logic in_acc = 1'b0;
    initial begin
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        cur = '{32'h0, 1'b0, 32'h0, 0, 32'h0, 1'b0};
        forever begin
            @(negedge swclk);
            if (psel && !penable) begin
                if (in_acc) chk("apb_setup_during_access", 32'h1, 32'h0);
                pready = 1'b0;
                acnt = 0;
                if (apb_q.size() == 0) begin
                    chk("apb_unexpected", paddr, 32'hFFFF_FFFF);
                    cur = '{32'h0, 1'b0, 32'h0, 0, 32'h0, 1'b0};
                end else begin
                    cur = apb_q.pop_front();
                    chk("apb_paddr", paddr, cur.addr);
                    chk("apb_pwrite", {31'h0, pwrite}, {31'h0, cur.write});
                    if (cur.write) chk("apb_pwdata", pwdata, cur.wdata);
                end
            end else if (psel && penable) begin
                if (acnt == cur.waits) begin
                    pready = 1'b1; prdata = cur.rdata; pslverr = cur.err; in_acc = 1'b0;
                end else begin
                    pready = 1'b0; pslverr = 1'b0; in_acc = 1'b1;
                end
                acnt++;
            end else begin
                pready = 1'b0; pslverr = 1'b0; in_acc = 1'b0;
            end
        end
    end

    task automatic go(input logic [7:0] s, input logic [5:0] a, input logic w, input logic [31:0] d);
        @(posedge swclk); #1;
        ap_sel = s; ap_addr = a; ap_wdata = d; ap_wen = w; ap_ren = !w;
        @(posedge swclk); #1;
        ap_wen = 1'b0; ap_ren = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge swclk); #1;
            n++;
        end while (!(ap_rdy && !mon_pend) && n < 200);
        if (n >= 200) chk("wait_idle_timeout", n, 0);
    endtask

    task automatic rd(input logic [7:0] s, input logic [5:0] a, input logic [31:0] exp);
        rsp_q.push_back('{1'b1, exp, 1'b0, 1});
        go(s, a, 1'b0, 32'h0);
        wait_idle();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        rsp_q.push_back('{1'b0, 32'h0, 1'b0, 1});
        go(8'd0, a, 1'b1, d);
        wait_idle();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ap_sel = 8'd0; ap_addr = 6'h0; ap_wdata = 32'h0;
        ap_wen = 1'b0; ap_ren = 1'b0; ap_abort = 1'b0;
        repeat (3) @(posedge swclk);
        #1 rst = 1'b0;
        @(negedge swclk);
        chk("rst_psel", {31'h0, psel}, 32'h0);
        chk("rst_penable", {31'h0, penable}, 32'h0);
        chk("rst_pwrite", {31'h0, pwrite}, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_rdata", ap_rdata, 32'h0);
        chk("rst_rdy", {31'h0, ap_rdy}, 32'h1);
        chk("rst_err", {31'h0, ap_err}, 32'h0);

        // Register map and AP selection
        rd(8'd0, 6'h00, 32'h0000_0042);
        rd(8'd0, 6'h3F, 32'h0477_0002);
        rd(8'd1, 6'h3F, 32'h0);
        rd(8'd0, 6'h3E, 32'h0000_0003);
        rd(8'd0, 6'h3D, 32'h0);
        rd(8'd0, 6'h01, 32'h0);

        // AddrInc single with 1 KiB page wrap
        wr(6'h00, 32'h0000_0010);
        rd(8'd0, 6'h00, 32'h0000_0052);
        wr(6'h01, 32'h0000_03FF);
        rd(8'd0, 6'h01, 32'h0000_03FC);
        apb_q.push_back('{32'h0000_03FC, 1'b1, 32'hA5A5_0001, 0, 32'h0, 1'b0});
        rsp_q.push_back('{1'b0, 32'h0, 1'b0, 3});
        go(8'd0, 6'h03, 1'b1, 32'hA5A5_0001);
        wait_idle();
        rd(8'd0, 6'h01, 32'h0000_0000);
        apb_q.push_back('{32'h0000_0000, 1'b1, 32'h0000_0002, 0, 32'h0, 1'b0});
        rsp_q.push_back('{1'b0, 32'h0, 1'b0, 3});
        go(8'd0, 6'h03, 1'b1, 32'h0000_0002);
        wait_idle();
        rd(8'd0, 6'h01, 32'h0000_0004);

        // Banked data
        wr(6'h00, 32'h0);
        wr(6'h01, 32'h2000_0010);
`ifdef OPENDAP_MEM_AP_BANKED_DATA_EN
        apb_q.push_back('{32'h2000_0018, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0});
        rsp_q.push_back('{1'b1, 32'h1234_5678, 1'b0, 5});
        go(8'd0, 6'h06, 1'b0, 32'h0);
        wait_idle();
        chk("bd2_paddr_held", paddr, 32'h2000_0018);
`else
        wr(6'h04, 32'hDEAD_BEEF);
        rd(8'd0, 6'h04, 32'h0);
        chk("bd_no_psel", {31'h0, psel}, 32'h0);
`endif
        rd(8'd0, 6'h01, 32'h2000_0010);

        // Slave error: err on the rdy rise cycle, no increment
        wr(6'h00, 32'h0000_0010);
        wr(6'h01, 32'h0000_0100);
        apb_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 1, 32'hDEAD_0000, 1'b1});
        rsp_q.push_back('{1'b0, 32'h0, 1'b1, 4});
        go(8'd0, 6'h03, 1'b0, 32'h0);
        wait_idle();
        rd(8'd0, 6'h01, 32'h0000_0100);

        // Abort with a long-waited read, then a queued write behind the orphan
        apb_q.push_back('{32'h0000_0100, 1'b0, 32'h0, 20, 32'hBAD0_BAD0, 1'b0});
        rsp_q.push_back('{1'b0, 32'h0, 1'b0, 5});
        go(8'd0, 6'h03, 1'b0, 32'h0);
        repeat (3) @(posedge swclk);
        #1 ap_abort = 1'b1;
        @(posedge swclk);
        #1 ap_abort = 1'b0;
        wait_idle();
        rd(8'd0, 6'h00, 32'h0000_00D2);
        apb_q.push_back('{32'h0000_0100, 1'b1, 32'h0000_0077, 0, 32'h0, 1'b0});
        rsp_q.push_back('{1'b0, 32'h0, 1'b0, 0});
        go(8'd0, 6'h03, 1'b1, 32'h0000_0077);
        wait_idle();
        rd(8'd0, 6'h01, 32'h0000_0104);

        // Reset mid-transfer: bus drops, nothing reported
        apb_q.push_back('{32'h0000_0104, 1'b0, 32'h0, 10, 32'h0, 1'b0});
        go(8'd0, 6'h03, 1'b0, 32'h0);
        repeat (2) @(posedge swclk);
        #1 rst = 1'b1;
        @(posedge swclk);
        #1 rst = 1'b0;
        @(negedge swclk);
        chk("rst_mid_psel", {31'h0, psel}, 32'h0);
        chk("rst_mid_penable", {31'h0, penable}, 32'h0);
        chk("rst_mid_rdy", {31'h0, ap_rdy}, 32'h1);
        rd(8'd0, 6'h00, 32'h0000_0042);
        rd(8'd0, 6'h01, 32'h0);

        repeat (3) @(negedge swclk);
        chk("apb_q_empty", apb_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/opendap_mem_ap_apb.md
# opendap_mem_ap_apb

MEM-AP that sits directly downstream of the SW-DP and consumes its AP interface (sel/addr/wdata/wen/ren/abort, returning rdata/rdy/err). It decodes the standard MEM-AP register map and turns DRW/BDn accesses into 32-bit APB3 master transfers. It is single-clock, shares `swclk` with the DP, and responds only when the DP's selected AP number matches `APSEL`.

## Interface
- `APSEL`, 8'd0, AP number this instance answers to
- `IDR`, 32'h0477_0002, value returned for IDR (0xFC)
- `BASE`, 32'h0000_0003, value returned for BASE (0xF8)
- `swclk  in  1  clock, shared with DP`
- `rst  in  1  reset; one clock; reset is synchronous and active-high`
- `ap_sel  in  8  selected AP, valid with wen/ren`
- `ap_addr  in  6  word address {APBANKSEL, A[3:2]}; byte offset = {ap_addr, 2'b00}`
- `ap_wdata  in  32  write data, valid with wen`
- `ap_wen / ap_ren  in  1  one-cycle access strobes, never both high together`
- `ap_abort  in  1  DAPABORT strobe`
- `ap_rdata  out  32  read data, held until next wen/ren`
- `ap_rdy  out  1  AP ready`
- `ap_err  out  1  error, high only on first rdy cycle after an access`
- `paddr  out  32`, `psel  out  1`, `penable  out  1`, `pwrite  out  1`, `pwdata  out  32`: APB3 master request
- `prdata  in  32`, `pready  in  1`, `pslverr  in  1`: APB3 completion

## Operation
- Register map (byte offset): CSW 0x00, TAR 0x04, DRW 0x0C, BD0–BD3 0x10–0x1C, CFG 0xF4 (RAZ), BASE 0xF8, IDR 0xFC; all others RAZ/WI.
- CSW: [5:4] AddrInc RW (00 off, 01 single, 1x treated as off, reads back as written); [2:0] Size RO 3'b010; [6] DeviceEn RO 1; [7] TrInProg RO = APB state != IDLE. Other bits RAZ/WI.
- TAR: 32-bit RW; bits [1:0] write-ignored, read 0.
- `ap_sel != APSEL`: reads return 0, writes ignored, no APB access, rdy stays high, err 0.
- Register (non-DRW/BDn) accesses: zero-wait; rdata registered at end of ren cycle; rdy stays high.
- DRW access: APB transfer to paddr = TAR. BDn access: paddr = {TAR[31:4], n[1:0], 2'b00}, never increments TAR.
- AddrInc single: on successful (pslverr=0) DRW completion, TAR[9:2] += 1, wrapping inside the 1 KiB page; TAR[31:10] unchanged.
- APB FSM: IDLE → SETUP (psel=1, penable=0) → ACCESS (psel=1, penable=1) → IDLE when pready. paddr/pwrite/pwdata registered at launch and stable through ACCESS.
- Completion: read → ap_rdata <= prdata; ap_err <= pslverr for one cycle with rdy rising.
- Abort: `ap_abort` while an APB transfer is in flight → ap_rdy high next cycle, ap_err 0. APB transfer is orphaned: it runs to pready legally; its rdata, pslverr and TAR increment are discarded. Abort while idle: no effect.
- New DRW/BDn access while orphan pending: rdy low; new transfer launches in the cycle after orphan completes.
- Register accesses during orphan: serviced zero-wait (TAR/CSW writes affect only later transfers).
- wen/ren while rdy low: ignored (DP protocol guarantees this does not occur).

## Timing
- Reset values: psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, ap_rdata 0, ap_rdy 1, ap_err 0; CSW.AddrInc 00; TAR 0.
- DRW/BDn, strobe at cycle T: rdy low from T+1; SETUP at T+1; ACCESS at T+2; pready at T+2+k → rdy high and rdata/err valid at T+3+k. Minimum latency 3 cycles.
- Abort at cycle A: rdy high at A+1.
- Reset mid-transfer: psel/penable drop in the cycle after rst; orphan discarded, no completion reported.

## Configuration
- `OPENDAP_MEM_AP_BANKED_DATA_EN` defined: BD0–BD3 perform APB transfers as above.
- Not defined: BD0–BD3 RAZ/WI, zero-wait, no APB access; BD addressing logic absent.

## Test plan
- Write CSW=0x10, TAR=0x0000_03FC; DRW write 0xA5A5_0001 then DRW write 0x2 → APB writes at 0x3FC then 0x000 (page wrap); TAR reads 0x0000_0000.
- TAR=0x2000_0010, BD2 read with prdata=0x1234_5678, pready after 2 waits → rdy low 5 cycles, rdata 0x1234_5678, err 0, TAR unchanged, paddr 0x2000_0018.
- DRW read with pslverr=1 → ap_err high exactly on rdy rise cycle; TAR not incremented with AddrInc=01.
- DRW read, pready held low 20 cycles, abort at cycle 4 → rdy high cycle 5; DRW write issued next → psel for it only after first transfer's pready.
- ap_sel=APSEL+1, read IDR → rdata 0, no psel; ap_sel=APSEL read IDR → `IDR`, CSW reads 0x0000_0042 after reset.
- Macro undefined: BD0 write → no psel, rdy never low, BD0 reads 0.
